// File: rtl/video_pkg.sv
// Shared raster timing defaults, counter/adjust widths and the sync window decode
// used by the video timing generator.
package video_pkg;

  localparam int CNT_W = 9;
  localparam int ADJ_W = 4;
  localparam int CMP_W = 10;

  localparam int DEF_CEN_DIV  = 8;
  localparam int DEF_H_TOTAL  = 384;
  localparam int DEF_H_ACTIVE = 256;
  localparam int DEF_HS_START = 304;
  localparam int DEF_HS_WIDTH = 32;
  localparam int DEF_V_TOTAL  = 264;
  localparam int DEF_V_ACTIVE = 224;
  localparam int DEF_VS_START = 240;
  localparam int DEF_VS_WIDTH = 3;

  // Signed window test; positions never exceed TOTAL-1, so windows running
  // off the end of the line/frame are clipped rather than wrapped.
  function automatic logic in_window(input logic [CNT_W-1:0] pos,
                                     input int               start,
                                     input logic [ADJ_W-1:0] adj,
                                     input int               width);
    logic signed [CMP_W-1:0] p;
    logic signed [CMP_W-1:0] lo;
    logic signed [CMP_W-1:0] hi;
    p  = signed'({1'b0, pos});
    lo = CMP_W'(start) + {{(CMP_W-ADJ_W){adj[ADJ_W-1]}}, adj};
    hi = lo + CMP_W'(width);
    return (p >= lo) && (p < hi);
  endfunction

endpackage

// File: rtl/video_timing_clk_en.sv
// Clock-enable divider: one-cycle registered pulse every DIV_MAX+1 clocks.
module clk_en #(
  parameter int DIV_MAX = 7
) (
  input  logic clk,
  input  logic rst_n,
  output logic ce
);

  localparam int W = (DIV_MAX < 1) ? 1 : $clog2(DIV_MAX + 1);
  localparam logic [W-1:0] DIV_LAST = W'(DIV_MAX);

  logic [W-1:0] div;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div <= '0;
      ce  <= 1'b0;
    end else begin
      ce  <= (div == DIV_LAST);
      div <= (div == DIV_LAST) ? '0 : div + W'(1);
    end
  end

endmodule

// File: rtl/video_timing.sv
// Raster timing generator: pixel enable, H/V counters, blanking, sync with
// per-frame centering adjust, and a vblank-start pulse for the CPU interrupt.
module video_timing
  import video_pkg::*;
#(
  parameter int CEN_DIV  = DEF_CEN_DIV,
  parameter int H_TOTAL  = DEF_H_TOTAL,
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int HS_START = DEF_HS_START,
  parameter int HS_WIDTH = DEF_HS_WIDTH,
  parameter int V_TOTAL  = DEF_V_TOTAL,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int VS_START = DEF_VS_START,
  parameter int VS_WIDTH = DEF_VS_WIDTH
) (
  input  logic             clk_sys,
  input  logic             reset_n,
  input  logic [ADJ_W-1:0] h_adj,
  input  logic [ADJ_W-1:0] v_adj,
  output logic             ce_pix,
  output logic [CNT_W-1:0] hcnt,
  output logic [CNT_W-1:0] vcnt,
  output logic             hblank,
  output logic             vblank,
  output logic             hsync,
  output logic             vsync,
  output logic             vb_start,
  output logic             frame
);

  if (!(H_ACTIVE < H_TOTAL && H_TOTAL <= 512 &&
        V_ACTIVE < V_TOTAL && V_TOTAL <= 512 && CEN_DIV >= 2)) begin : g_param_err
    $error("video_timing: illegal timing parameters");
  end

  localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_ACT  = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_ACT  = CNT_W'(V_ACTIVE);

  logic [ADJ_W-1:0] hadj_l;
  logic [ADJ_W-1:0] vadj_l;
  logic             frame_wrap;
  logic [CNT_W-1:0] h_next;
  logic [CNT_W-1:0] v_next;
  logic [ADJ_W-1:0] hadj_next;
  logic [ADJ_W-1:0] vadj_next;
  logic             hblank_next;
  logic             vblank_next;
  logic             hsync_next;
  logic             vsync_next;

  clk_en #(
    .DIV_MAX(CEN_DIV - 1)
  ) u_clk_en (
    .clk  (clk_sys),
    .rst_n(reset_n),
    .ce   (ce_pix)
  );

  // Decode from the next counter values so registered outputs line up with
  // the counters they are presented beside.
  always_comb begin
    frame_wrap = 1'b0;
    h_next     = hcnt;
    v_next     = vcnt;
    if (hcnt == H_LAST) begin
      h_next = '0;
      if (vcnt == V_LAST) begin
        v_next     = '0;
        frame_wrap = 1'b1;
      end else begin
        v_next = vcnt + CNT_W'(1);
      end
    end else begin
      h_next = hcnt + CNT_W'(1);
    end
    hadj_next   = frame_wrap ? h_adj : hadj_l;
    vadj_next   = frame_wrap ? v_adj : vadj_l;
    hblank_next = (h_next >= H_ACT);
    vblank_next = (v_next >= V_ACT);
    hsync_next  = in_window(h_next, HS_START, hadj_next, HS_WIDTH);
    vsync_next  = in_window(v_next, VS_START, vadj_next, VS_WIDTH);
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      hcnt     <= '0;
      vcnt     <= '0;
      hblank   <= 1'b0;
      vblank   <= 1'b0;
      hsync    <= 1'b0;
      vsync    <= 1'b0;
      vb_start <= 1'b0;
      frame    <= 1'b0;
      hadj_l   <= '0;
      vadj_l   <= '0;
    end else begin
      vb_start <= 1'b0;
      if (ce_pix) begin
        hcnt     <= h_next;
        vcnt     <= v_next;
        hblank   <= hblank_next;
        vblank   <= vblank_next;
        hsync    <= hsync_next;
        vsync    <= vsync_next;
        vb_start <= vblank_next & ~vblank;
        if (frame_wrap) begin
          frame  <= ~frame;
          hadj_l <= h_adj;
          vadj_l <= v_adj;
        end
      end
    end
  end

endmodule

// File: doc/video_timing.md
Name: video_timing

Overview:
- Raster timing generator that sits directly upstream of the main CPU wrapper.
- Produces the pixel clock enable, H/V counters, blanking and sync signals.
- Its vblank output is the `vb` input the main CPU wrapper edge-detects to raise INT.
- Sync positions can be adjusted per frame for screen centering; adjustments are applied only at frame boundaries.

Parameters:
- CEN_DIV, 8: clk_sys cycles per pixel; ce_pix pulses once per CEN_DIV cycles.
- H_TOTAL, 384: pixels per line, counted 0..H_TOTAL-1.
- H_ACTIVE, 256: visible pixels; hblank when hcnt >= H_ACTIVE.
- HS_START, 304: nominal hsync assert column.
- HS_WIDTH, 32: hsync width in pixels.
- V_TOTAL, 264: lines per frame.
- V_ACTIVE, 224: visible lines; vblank when vcnt >= V_ACTIVE.
- VS_START, 240: nominal vsync assert line.
- VS_WIDTH, 3: vsync width in lines.

Ports:
- clk_sys  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- h_adj  in  4  signed hsync offset in pixels, -8..+7
- v_adj  in  4  signed vsync offset in lines, -8..+7
- ce_pix  out  1  one-clk_sys-cycle pixel enable
- hcnt  out  9  horizontal pixel count
- vcnt  out  9  line count
- hblank  out  1  horizontal blank, active high
- vblank  out  1  vertical blank, active high; drives main CPU `vb`
- hsync  out  1  horizontal sync, active high
- vsync  out  1  vertical sync, active high
- vb_start  out  1  one-clk_sys pulse on the first cycle vblank is high
- frame  out  1  toggles at each frame wrap

Behaviour:
- Reset (async on reset_n low):
  - divider counter = 0; ce_pix, hcnt, vcnt, hblank, vblank, hsync, vsync, vb_start, frame all = 0.
  - latched adjusts = 0.
  - Release is synchronous: the first ce_pix comes CEN_DIV cycles after reset_n rises.
- Divider:
  - div counts 0..CEN_DIV-1 and wraps.
  - ce_pix is registered and high exactly in the cycle after div==CEN_DIV-1.
  - Period is CEN_DIV, duty 1/CEN_DIV.
- Counter advance (on the same clk_sys edge that ce_pix is high):
  - hcnt <= (hcnt==H_TOTAL-1) ? 0 : hcnt+1.
  - On the hcnt wrap: vcnt <= (vcnt==V_TOTAL-1) ? 0 : vcnt+1.
  - On the vcnt wrap: frame toggles.
- Output timing:
  - hblank, vblank, hsync and vsync are registered from the next counter values, so they are always coherent with the hcnt/vcnt presented in the same cycle.
  - Zero latency relative to the counters.
- Sync decode:
  - hsync = hcnt in [HS_START+hadj_l, HS_START+hadj_l+HS_WIDTH).
  - vsync = vcnt in [VS_START+vadj_l, VS_START+vadj_l+VS_WIDTH).
  - Compares use 10-bit signed arithmetic; a window that runs past TOTAL-1 is clipped at TOTAL-1 and does not wrap.
- Adjust latching:
  - hadj_l/vadj_l sample h_adj/v_adj only on the vcnt wrap to 0.
  - Mid-frame changes of h_adj/v_adj have no effect until the next frame.
- vb_start:
  - High for one clk_sys cycle, the cycle vblank goes 0->1, i.e. at the line V_ACTIVE, hcnt 0 transition.
  - Never asserted when vblank is already high.
- Blanking is independent of h_adj/v_adj.
- Boundaries:
  - Line V_TOTAL-1, column H_TOTAL-1 wraps to (0,0); vblank and hblank fall on the same edge.
  - Reset mid-frame returns to (0,0) immediately; no vb_start pulse is generated by reset.
- Static parameter guards (checked in simulation): H_ACTIVE < H_TOTAL <= 512 and V_ACTIVE < V_TOTAL <= 512, CEN_DIV >= 2.

Decomposition:
- Shared package `video_pkg`: default timing constants (H_TOTAL, H_ACTIVE, HS_*, V_TOTAL, V_ACTIVE, VS_*), the 9-bit counter width, and the adjust width.
- One natural sub-module: `clk_en`, the existing clock-enable divider, instantiated with CEN_DIV-1.
- Everything else is inline: two counters plus compare logic.

Test Plan:
- Reset, then release with defaults -> first ce_pix 8 cycles later; ce_pix period exactly 8; hcnt reaches 383 then wraps to 0 with vcnt 0->1.
- Run one full frame -> 384*264*8 = 811008 clk_sys cycles between frame toggles; vblank rises at vcnt=224, hcnt=0, with a single vb_start pulse; vblank falls at (0,0).
- h_adj=0, v_adj=0 -> hsync high for hcnt 304..335, vsync high for vcnt 240..242; h_adj=-8 -> hsync 296..327 from the next frame.
- Change v_adj to +7 at vcnt=100 -> vsync stays at 240..242 this frame, moves to 247..249 the next frame.
- Parameter override H_TOTAL=320, HS_START=300, HS_WIDTH=32, h_adj=+7 -> hsync 307..319 (clipped), no wrap into hcnt 0.
- Assert reset_n low at vcnt=230 during vblank, hold 3 cycles -> all outputs 0 asynchronously; after release, no spurious vb_start; next vb_start occurs at vcnt=224 of the new frame.
